// File: rtl/alu_multicycle_if.sv
// Handshake bundle between the EX stage and the multicycle ALU.
// Latency: none (wires only).
// Backpressure: InValid/InReady on the issue side, OutValid/OutReady on the result side.
// Ports: master = issuing stage (drives op, operands, OutReady);
//        slave  = ALU (drives InReady, result, flags, Busy).
interface alu_multicycle_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
);
    logic             InValid;
    logic             InReady;
    logic [OPW-1:0]   ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] Hi;
    logic             Zero;
    logic             DivByZero;
    logic             Busy;

    modport master (
        output InValid, ALUControl, A, B, OutReady,
        input  InReady, OutValid, Result, Hi, Zero, DivByZero, Busy
    );

    modport slave (
        input  InValid, ALUControl, A, B, OutReady,
        output InReady, OutValid, Result, Hi, Zero, DivByZero, Busy
    );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: 1-cycle logic/shift/compare ops, iterative MUL/MULU/DIV/DIVU.
// Latency: accept->OutValid 1 cycle (single-cycle ops, div-by-zero), WIDTH+1 cycles (MUL/DIV).
// Backpressure: result held while OutReady=0; InReady only in IDLE or when the result is consumed.
// Ports: Clk, Reset (async active-low); bus (slave modport) carries op/operands,
//        result/flags, both handshakes and Busy.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input logic          Clk,
    input logic          Reset,
    alu_multicycle_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(5'b10110);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_NOR  = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_SLT  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_SLTU = OPW'(5'b10111);
    localparam logic [OPW-1:0] OP_MULU = OPW'(5'b10011);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10100);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(5'b10101);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // MUL: running high product; DIV: partial remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // MUL: multiplier/low product; DIV: dividend/quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;       // MUL: multiplicand magnitude; DIV: divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;     // negate product / quotient at the end
    logic             neg_r_q, neg_r_d;     // negate remainder at the end
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic             in_fire;
    logic             op_mul, op_div, op_sgn;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;

    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fin_res, fin_hi;

    assign bus.InReady   = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.OutReady);
    assign bus.OutValid  = (state_q == S_DONE);
    assign bus.Busy      = (state_q == S_ITER);
    assign bus.Result    = result_q;
    assign bus.Hi        = hi_q;
    assign bus.Zero      = zero_q;
    assign bus.DivByZero = dbz_q;

    assign in_fire = bus.InValid & bus.InReady;
    assign op_mul  = (bus.ALUControl == OP_MUL) | (bus.ALUControl == OP_MULU);
    assign op_div  = (bus.ALUControl == OP_DIV) | (bus.ALUControl == OP_DIVU);
    assign op_sgn  = (bus.ALUControl == OP_MUL) | (bus.ALUControl == OP_DIV);
    // Signed ops iterate on magnitudes; the signs are remembered for the last cycle.
    assign a_neg   = op_sgn & bus.A[WIDTH-1];
    assign b_neg   = op_sgn & bus.B[WIDTH-1];
    assign a_mag   = a_neg ? -bus.A : bus.A;
    assign b_mag   = b_neg ? -bus.B : bus.B;
    assign shamt   = bus.A[SHW-1:0];

    // Single-cycle datapath; MUL with B==0 and unknown opcodes fall to 0.
    always_comb begin
        sc_res = '0;
        case (bus.ALUControl)
            OP_ADD:  sc_res = bus.A + bus.B;
            OP_SUB:  sc_res = bus.A - bus.B;
            OP_SLL:  sc_res = bus.B << shamt;
            OP_SRL:  sc_res = bus.B >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(bus.B) >>> shamt);
            OP_AND:  sc_res = bus.A & bus.B;
            OP_OR:   sc_res = bus.A | bus.B;
            OP_XOR:  sc_res = bus.A ^ bus.B;
            OP_NOR:  sc_res = ~(bus.A | bus.B);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            default: sc_res = '0;
        endcase
    end

    // One iteration step. MUL: add-if-lsb then shift {carry,hi,lo} right.
    // DIV: restoring step; since rem < divisor, bit WIDTH of the difference is the borrow.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ok   = ~div_diff[WIDTH];
        if (is_div_q) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = neg_q_q ? -prod : prod;
        quo_fix  = neg_q_q ? -step_lo : step_lo;
        rem_fix  = neg_r_q ? -step_hi : step_hi;
        fin_res  = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        fin_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_ITER: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = fin_res;
                    hi_d     = fin_hi;
                    zero_d   = (fin_res == '0);
                    dbz_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin  // IDLE and DONE share the accept path
                if (in_fire) begin
                    if ((op_mul | op_div) && (bus.B != '0)) begin
                        state_d  = S_ITER;
                        cnt_d    = CW'(WIDTH - 1);
                        acc_hi_d = '0;
                        acc_lo_d = op_div ? a_mag : b_mag;
                        opnd_d   = op_div ? b_mag : a_mag;
                        is_div_d = op_div;
                        neg_q_d  = a_neg ^ b_neg;
                        neg_r_d  = a_neg;
                    end else begin
                        state_d = S_DONE;
                        if (op_div) begin
                            result_d = '1;
                            hi_d     = bus.A;
                            zero_d   = 1'b0;
                            dbz_d    = 1'b1;
                        end else begin
                            result_d = sc_res;
                            hi_d     = '0;
                            zero_d   = (sc_res == '0);
                            dbz_d    = 1'b0;
                        end
                    end
                end else if ((state_q == S_DONE) && bus.OutReady) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed table, random ops vs. an
// arithmetic reference model, and hand sequences for backpressure and reset.
module tb_alu_multicycle;
    localparam logic [4:0] OP_ADD  = 5'b00001, OP_SUB  = 5'b00010, OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00100, OP_SRL  = 5'b00101, OP_SRA  = 5'b10110;
    localparam logic [4:0] OP_AND  = 5'b00110, OP_OR   = 5'b00111, OP_XOR  = 5'b01000;
    localparam logic [4:0] OP_NOR  = 5'b01101, OP_SLT  = 5'b01110, OP_SLTU = 5'b10111;
    localparam logic [4:0] OP_MULU = 5'b10011, OP_DIV  = 5'b10100, OP_DIVU = 5'b10101;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    alu_multicycle_if #(.WIDTH(32), .OPW(5)) bus ();
    alu_multicycle #(.WIDTH(32), .OPW(5)) dut (.Clk(clk), .Reset(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [31:0] h,
                                  output logic z, output logic d, output int lat);
        longint      sa, sb, q, rm;
        logic [63:0] p;
        int          sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a[4:0]);
        r = 32'd0; h = 32'd0; d = 1'b0; lat = 1;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = b << sh;
            OP_SRL:  r = b >> sh;
            OP_SRA:  r = $unsigned($signed(b) >>> sh);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_MUL, OP_MULU: begin
                if (op == OP_MUL) p = 64'(sa * sb);
                else              p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
                h = p[63:32];
                if (b != 0) lat = 33;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 0) begin
                    r = 32'hFFFF_FFFF; h = a; d = 1'b1;
                end else begin
                    lat = 33;
                    if (op == OP_DIV) begin
                        q = sa / sb; rm = sa % sb;
                        r = q[31:0]; h = rm[31:0];
                    end else begin
                        r = a / b; h = a % b;
                    end
                end
            end
            default: r = 32'd0;
        endcase
        z = (r == 32'd0);
    endfunction

    // Issue one op with OutReady held high, scramble inputs after acceptance,
    // then wait (bounded) for OutValid and compare everything.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic [31:0] eh,
                          input logic ez, input logic ed, input int elat);
        int cyc  = 0;
        int busy = 0;
        bit seen = 0;
        @(negedge clk);
        bus.OutReady = 1'b1;
        chk({tag, " in_ready"}, 64'(bus.InReady), 64'd1);
        bus.InValid = 1'b1; bus.ALUControl = op; bus.A = a; bus.B = b;
        @(posedge clk);
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.InValid = 1'b0;
            bus.A = $urandom; bus.B = $urandom; bus.ALUControl = 5'($urandom);
            if (bus.Busy) busy++;
            if (bus.OutValid) seen = 1;
        end
        chk({tag, " latency"}, seen ? 64'(cyc) : 64'hDEAD, 64'(elat));
        chk({tag, " busy_cycles"}, 64'(busy), 64'(elat - 1));
        chk({tag, " result"}, 64'(bus.Result), 64'(er));
        chk({tag, " hi"}, 64'(bus.Hi), 64'(eh));
        chk({tag, " zero"}, 64'(bus.Zero), 64'(ez));
        chk({tag, " div_by_zero"}, 64'(bus.DivByZero), 64'(ed));
    endtask

    vec_t        vecs[15];
    logic [4:0]  ops[17];
    logic [31:0] ra, rb, mr, mh;
    logic        mz, md;
    int          ml;

    function automatic logic [31:0] pick_operand(input bit allow_zero);
        case ($urandom_range(0, 4))
            0:       return allow_zero ? 32'd0 : 32'd3;
            1:       return 32'($urandom_range(1, 20));
            2:       return 32'h8000_0000;
            3:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 32'h0,         1'b0, 1'b0, 1};
        vecs[1]  = '{OP_MUL,  32'hFFFF_FFFD, 32'h7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[3]  = '{OP_DIVU, 32'h5,         32'h0,         32'hFFFF_FFFF, 32'h5,         1'b0, 1'b1, 1};
        vecs[4]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 33};
        vecs[5]  = '{OP_SRA,  32'h4,         32'h8000_0000, 32'hF800_0000, 32'h0,         1'b0, 1'b0, 1};
        vecs[6]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0,         1'b0, 1'b0, 1};
        vecs[7]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0,         1'b1, 1'b0, 1};
        vecs[8]  = '{OP_NOR,  32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 1};
        vecs[9]  = '{5'b11111, 32'h1,        32'h2,         32'h0,         32'h0,         1'b1, 1'b0, 1};
        vecs[10] = '{OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE, 1'b0, 1'b0, 33};
        vecs[11] = '{OP_MUL,  32'h5,         32'h0,         32'h0,         32'h0,         1'b1, 1'b0, 1};
        vecs[12] = '{OP_DIV,  32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1,         1'b0, 1'b0, 33};
        vecs[13] = '{OP_SLL,  32'd36,        32'h1,         32'h10,        32'h0,         1'b0, 1'b0, 1};
        vecs[14] = '{OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0,         1'b0, 1'b0, 1};
        ops = '{OP_ADD, OP_SUB, OP_MUL, OP_SLL, OP_SRL, OP_SRA, OP_AND, OP_OR, OP_XOR,
                OP_NOR, OP_SLT, OP_SLTU, OP_MULU, OP_DIV, OP_DIVU, 5'b11111, 5'b01001};

        rst_n = 1'b0;
        bus.InValid = 1'b0; bus.ALUControl = '0; bus.A = '0; bus.B = '0; bus.OutReady = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset out_valid", 64'(bus.OutValid), 64'd0);
        chk("reset busy", 64'(bus.Busy), 64'd0);
        chk("reset result", 64'(bus.Result), 64'd0);
        chk("reset hi", 64'(bus.Hi), 64'd0);
        chk("reset flags", 64'({bus.Zero, bus.DivByZero}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 64'(bus.InReady), 64'd1);

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].hi, vecs[i].zero, vecs[i].dbz, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            ra = pick_operand(1'b0);
            rb = pick_operand(1'b1);
            model(ops[$urandom_range(0, 16)], ra, rb, mr, mh, mz, md, ml);
        end
        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = ops[$urandom_range(0, 16)];
            ra = pick_operand(1'b0);
            rb = pick_operand(1'b1);
            model(op, ra, rb, mr, mh, mz, md, ml);
            run_op($sformatf("rnd%0d op%0h", i, op), op, ra, rb, mr, mh, mz, md, ml);
        end

        // Backpressure: SUB 5-5 held for 4 cycles, a pending ADD waits for OutReady.
        @(negedge clk);
        bus.OutReady = 1'b0;
        bus.InValid = 1'b1; bus.ALUControl = OP_SUB; bus.A = 32'd5; bus.B = 32'd5;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.ALUControl = OP_ADD; bus.A = 32'd2; bus.B = 32'd3;
            end
            chk($sformatf("bp%0d out_valid", i), 64'(bus.OutValid), 64'd1);
            chk($sformatf("bp%0d result", i), 64'(bus.Result), 64'd0);
            chk($sformatf("bp%0d zero", i), 64'(bus.Zero), 64'd1);
            chk($sformatf("bp%0d in_ready", i), 64'(bus.InReady), 64'd0);
        end
        bus.OutReady = 1'b1;
        #1;
        chk("bp in_ready on OutReady", 64'(bus.InReady), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.InValid = 1'b0;
        chk("bp next out_valid", 64'(bus.OutValid), 64'd1);
        chk("bp next result", 64'(bus.Result), 64'd5);
        chk("bp next zero", 64'(bus.Zero), 64'd0);

        // Reset in the middle of a MULU iteration.
        @(negedge clk);
        bus.InValid = 1'b1; bus.ALUControl = OP_MULU; bus.A = 32'h1234; bus.B = 32'h5678;
        @(posedge clk);
        repeat (10) @(negedge clk);
        bus.InValid = 1'b0;
        chk("mid-iter busy", 64'(bus.Busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 64'(bus.OutValid), 64'd0);
        chk("abort busy", 64'(bus.Busy), 64'd0);
        chk("abort result", 64'(bus.Result), 64'd0);
        chk("abort hi", 64'(bus.Hi), 64'd0);
        chk("abort flags", 64'({bus.Zero, bus.DivByZero}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release in_ready", 64'(bus.InReady), 64'd1);
        run_op("after reset add", OP_ADD, 32'd2, 32'd2, 32'd4, 32'd0, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
